decrement_counter: RTL
======================

Name: decrement_counter

Overview:
Parametrised, registered step-decrement counter. Generalises our 8-bit combinational decrementer:
- Adds a load.
- Adds a variable step size.
- Selects saturating or wrapping arithmetic at run time.
- Flags zero and underflow.
- Tracks a RUN/IDLE state for countdown-timer use.
Sits in datapath and timer logic wherever a held value must count down under enable.

Parameters:
WIDTH, 8, width of Count and Load_Value
STEP_W, 4, width of Step input
RESET_VAL, 0, Count value after reset

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
Load  input  1  load Load_Value into Count on next edge
Load_Value  input  WIDTH  value to load
Dec_En  input  1  decrement Count by Step on next edge
Step  input  STEP_W  decrement amount, unsigned, zero-extended to WIDTH
Saturate  input  1  1 = clamp at 0 on underflow, 0 = wrap modulo 2^WIDTH
Count  output  WIDTH  registered counter value
Zero  output  1  combinational, Count == 0
Underflow  output  1  registered one-cycle pulse, last decrement had Step > Count
Busy  output  1  registered, 1 in RUN state

Behaviour:
- Reset (rst_n low, asynchronous): Count=RESET_VAL; Underflow=0; state IDLE (Busy=0); Zero follows Count.
- Deassertion is sampled at the next rising edge.
- Reset mid-operation aborts immediately, with no pending update.
- Latency: Count, Underflow and Busy update one clock after Load/Dec_En is sampled. Zero is valid in the same cycle as Count.
- Priority: Load over Dec_En. When both are high, Dec_En is ignored.
- Load:
  - Count <= Load_Value; Underflow <= 0.
  - State <= RUN if Load_Value != 0, else IDLE.
- Dec_En (Load low): the difference is computed in WIDTH+1 bits.
  - Step <= Count: Count <= Count - Step; Underflow <= 0.
  - Step > Count, Saturate=1: Count <= 0; Underflow <= 1.
  - Step > Count, Saturate=0: Count <= (Count - Step) mod 2^WIDTH; Underflow <= 1.
  - Step = 0: Count holds, Underflow <= 0, state unchanged.
- Neither Load nor Dec_En: Count holds; Underflow <= 0.
- State machine, IDLE/RUN:
  - IDLE -> RUN on Load with nonzero value.
  - RUN -> IDLE when a decrement makes Count exactly 0, or underflows (either mode).
  - RUN -> IDLE on Load of 0.
  - Dec_En in IDLE still decrements (free-running use) but never enters RUN.
- Underflow is a single-cycle pulse. Back-to-back underflowing decrements give a continuously high Underflow.
- Count=0 with Dec_En and Step != 0:
  - Saturate=1: Count stays 0, Underflow=1.
  - Saturate=0: Count = 2^WIDTH - Step, Underflow=1.
- Saturate is sampled per cycle and may change between decrements.

Optional Feature:
DECREMENT_COUNTER_AUTO_RELOAD_EN
- Defined:
  - Adds a WIDTH-bit Reload register, captured from Load_Value on every Load; reset value RESET_VAL.
  - In RUN, a terminal decrement (Step >= Count, Step != 0) sets Count <= Reload and Underflow <= 1. Saturate is ignored; state stays RUN.
  - Periodic timer operation; IDLE behaviour is unchanged.
- Undefined: no Reload register; behaviour exactly as above.

Test Plan:
- Reset: hold rst_n=0 asynchronously mid-cycle -> Count=0x00, Zero=1, Busy=0, Underflow=0 immediately.
- Load 0x05, then Dec_En with Step=1 for 5 cycles -> Count 4,3,2,1,0; Busy=1 until Count=0, then 0; Underflow never set.
- Count=0x03, Step=5, Saturate=1 -> Count=0x00, Underflow pulses 1 cycle, Busy 1->0. Repeat with Saturate=0 -> Count=0xFE, Underflow=1.
- Load=1, Dec_En=1, Load_Value=0x10 in same cycle -> Count=0x10 (no decrement), Busy=1. Next cycle Step=0 -> Count holds 0x10.
- Count=0x00, Dec_En, Step=1, Saturate=0 -> Count=0xFF, Underflow=1, Busy stays 0.
- With DECREMENT_COUNTER_AUTO_RELOAD_EN: Load 0x03, Step=1 continuous -> Count 2,1,3,2,1,3...; Underflow pulses on each reload; Busy stays 1.

Source files
------------

// File: rtl/decrement_counter.sv
// decrement_counter: registered step-decrement counter with load, run-time
// saturate/wrap select, zero and underflow flags, and an IDLE/RUN tracker.
// Optional build macro DECREMENT_COUNTER_AUTO_RELOAD_EN: RUN-state terminal
// decrements reload Count from the value captured on the last Load.
module decrement_counter #(
  parameter int WIDTH     = 8,
  parameter int STEP_W    = 4,
  parameter int RESET_VAL = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Load,
  input  logic [WIDTH-1:0]  Load_Value,
  input  logic              Dec_En,
  input  logic [STEP_W-1:0] Step,
  input  logic              Saturate,
  output logic [WIDTH-1:0]  Count,
  output logic              Zero,
  output logic              Underflow,
  output logic              Busy
);

  // Difference width: one extra bit so the MSB is the borrow (Step > Count).
  localparam int DW = ((STEP_W > WIDTH) ? STEP_W : WIDTH) + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_d;
  logic [WIDTH-1:0] count_d;
  logic             unf_d;
  logic [DW-1:0]    diff;
  logic             borrow;
  logic             step_nz;
  logic             diff_zero;

`ifdef DECREMENT_COUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload, reload_d;
`endif

  // Widened subtraction shared by all decrement cases.
  always_comb begin
    diff      = DW'(Count) - DW'(Step);
    borrow    = diff[DW-1];
    step_nz   = (Step != '0);
    diff_zero = (diff == '0);
  end

  // Next-state / next-count: Load wins over Dec_En; Step==0 is a no-op.
  always_comb begin
    state_d  = state;
    count_d  = Count;
    unf_d    = 1'b0;
`ifdef DECREMENT_COUNTER_AUTO_RELOAD_EN
    reload_d = reload;
`endif
    if (Load) begin
      count_d = Load_Value;
      state_d = (Load_Value != '0) ? RUN : IDLE;
`ifdef DECREMENT_COUNTER_AUTO_RELOAD_EN
      reload_d = Load_Value;
`endif
    end else if (Dec_En && step_nz) begin
`ifdef DECREMENT_COUNTER_AUTO_RELOAD_EN
      if (state == RUN && (borrow || diff_zero)) begin
        // Periodic timer: wrap back to the reload value and stay running.
        count_d = reload;
        unf_d   = 1'b1;
      end else
`endif
      if (borrow) begin
        count_d = Saturate ? '0 : diff[WIDTH-1:0];
        unf_d   = 1'b1;
        state_d = IDLE;
      end else begin
        count_d = diff[WIDTH-1:0];
        if (diff_zero) state_d = IDLE;
      end
    end
  end

  // State, count and underflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      Count     <= WIDTH'(RESET_VAL);
      Underflow <= 1'b0;
    end else begin
      state     <= state_d;
      Count     <= count_d;
      Underflow <= unf_d;
    end
  end

`ifdef DECREMENT_COUNTER_AUTO_RELOAD_EN
  // Reload value captured on every Load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) reload <= WIDTH'(RESET_VAL);
    else        reload <= reload_d;
  end
`endif

  assign Busy = (state == RUN);
  assign Zero = (Count == '0);

endmodule
